// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI coprocessor datapath in the TinyTapeout wrapper.
//
// Contents:
//   PCPI_DATA_W   width of a coprocessor result word
//   PCPI_NIB_W    width of one pin-interface transfer segment
//   ser_state_e   state encoding of the result serializer FSM
//
// The widths are also used by the upstream nibble assembler, so both directions of the
// pin interface agree on segment size.

package pcpi_pkg;

    localparam int unsigned PCPI_DATA_W = 32;
    localparam int unsigned PCPI_NIB_W  = 4;

    typedef enum logic [1:0] {
        SER_IDLE     = 2'b00,
        SER_PRESENT  = 2'b01,
        SER_WAIT_LOW = 2'b10,
        SER_DONE     = 2'b11
    } ser_state_e;

endpackage

// File: rtl/pcpi_result_serializer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; both flops clear to 0
//   d      asynchronous input level
//   q      input level re-timed to clk, two cycles of latency
//
// Only instantiated by pcpi_result_serializer when PCPI_SER_ACK_SYNC_EN is defined.

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pcpi_result_serializer.sv
// PCPI result serializer.
//
// Captures the coprocessor result word when pcpi_ready is strobed together with pcpi_wr,
// then streams it to the host one segment at a time, least-significant segment first.
// Each segment uses a four-phase handshake with the host:
//   nib_valid rises -> host raises host_ack -> nib_valid falls -> host drops host_ack
//   -> next segment presented.
// busy stays high from capture until the cycle after the done pulse so the upstream
// instruction-assembly logic can hold off the next pcpi_valid.
//
// Configuration macro:
//   PCPI_SER_ACK_SYNC_EN  when defined, host_ack passes through a 2-flop synchronizer
//                         (sync_2ff) before the FSM; every ack edge is seen 2 cycles later.
//                         When undefined, host_ack must be synchronous to clk.
//
// Parameters:
//   DATA_W  width of the captured result (integer multiple of NIB_W)
//   NIB_W   width of one transferred segment
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset; aborts any transfer in progress
//   pcpi_ready  coprocessor completion strobe (single cycle)
//   pcpi_wr     result-valid qualifier, sampled with pcpi_ready
//   pcpi_rd     coprocessor result, sampled with pcpi_ready
//   host_ack    host acknowledge level
//   nib_out     current segment (holds its value while nib_valid is low)
//   nib_valid   segment on nib_out is stable and presented
//   nib_idx     index of the presented segment
//   busy        a result is held or in transfer
//   done        single-cycle pulse after the last segment completes
//   overrun     sticky: a result arrived while busy and was dropped
//
// All outputs come straight from flops; no input reaches an output combinationally.

module pcpi_result_serializer
    import pcpi_pkg::*;
#(
    parameter  int unsigned DATA_W = PCPI_DATA_W,
    parameter  int unsigned NIB_W  = PCPI_NIB_W,
    localparam int unsigned NSEG   = DATA_W / NIB_W,
    localparam int unsigned IDX_W  = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcpi_ready,
    input  logic              pcpi_wr,
    input  logic [DATA_W-1:0] pcpi_rd,
    input  logic              host_ack,
    output logic [NIB_W-1:0]  nib_out,
    output logic              nib_valid,
    output logic [IDX_W-1:0]  nib_idx,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

    // ------------------------------------------------------------------
    // Acknowledge conditioning
    // ------------------------------------------------------------------
    logic ack;

`ifdef PCPI_SER_ACK_SYNC_EN
    sync_2ff u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (host_ack),
        .q     (ack)
    );
`else
    assign ack = host_ack;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              overrun_q, overrun_d;

    logic [NIB_W-1:0]  nib_out_q, nib_out_d;
    logic              nib_valid_q, nib_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              capture;

    assign capture = pcpi_ready & pcpi_wr;

    // Next-state logic for the FSM, counter, shift register and sticky flag.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        case (state_q)
            SER_IDLE: begin
                if (capture) begin
                    shreg_d = pcpi_rd;
                    cnt_d   = '0;
                    state_d = SER_PRESENT;
                end
            end

            SER_PRESENT: begin
                // An ack that is already high on entry counts immediately; WAIT_LOW then
                // forces the host to release it before the next segment is offered.
                if (ack) begin
                    state_d = SER_WAIT_LOW;
                end
            end

            SER_WAIT_LOW: begin
                if (!ack) begin
                    shreg_d = shreg_q >> NIB_W;
                    if (cnt_q == LAST_IDX) begin
                        state_d = SER_DONE;
                    end else begin
                        cnt_d   = cnt_q + IDX_W'(1);
                        state_d = SER_PRESENT;
                    end
                end
            end

            SER_DONE: begin
                cnt_d   = '0;
                state_d = SER_IDLE;
            end

            default: begin
                state_d = SER_IDLE;
            end
        endcase

        // A second result while busy (DONE included) is dropped, never queued.
        if (capture && (state_q != SER_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Output registers are loaded from the next state so they line up with state_q.
    always_comb begin
        nib_valid_d = (state_d == SER_PRESENT);
        busy_d      = (state_d != SER_IDLE);
        done_d      = (state_d == SER_DONE);
        nib_out_d   = nib_out_q;
        if (state_d == SER_PRESENT) begin
            nib_out_d = shreg_d[NIB_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SER_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            nib_out_q   <= '0;
            nib_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            nib_out_q   <= nib_out_d;
            nib_valid_q <= nib_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign nib_out   = nib_out_q;
    assign nib_valid = nib_valid_q;
    assign nib_idx   = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule
